// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the single common data bus.
// Picks at most one valid functional-unit result per cycle, acknowledges it
// combinationally on req_ready, and broadcasts its ROB tag/value on the
// registered cdb_* outputs one cycle later.
// Optional feature macro: CDB_PERF_CNT_EN (per-requester grant counters and a
// contention counter exposed as extra output ports).
//
// Handshake: a transfer happens in a cycle where req_valid[i] && req_ready[i].
// A requester keeps valid/tag/value stable until it sees ready; req_ready is
// computed only from req_valid, rr_ptr, reset and flush, never from itself.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int REQ_IDX_W = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*`ROB_TAG_LEN-1:0] req_rob_tag,
    input  logic [NUM_REQ*`XLEN-1:0]        req_value,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            cdb_valid,
    output logic [`ROB_TAG_LEN-1:0]         cdb_rob_tag,
    output logic [`XLEN-1:0]                cdb_value,
    output logic [REQ_IDX_W-1:0]            cdb_src
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*32-1:0]           perf_grant_cnt,
    output logic [31:0]                     perf_conflict_cnt
`endif
);

    // Reject unsupported configurations at elaboration time.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("cdb_arbiter: NUM_REQ must be in 2..8");
    end
    if (REQ_IDX_W < $clog2(NUM_REQ)) begin : g_bad_idx_w
        $error("cdb_arbiter: REQ_IDX_W too narrow for NUM_REQ");
    end

    // Round-robin pointer: first index searched in the next cycle.
    logic [REQ_IDX_W-1:0]    rr_ptr;

    // Arbitration results for the current cycle.
    logic [NUM_REQ-1:0]      grant;
    logic                    grant_any;
    logic [REQ_IDX_W-1:0]    grant_idx;
    logic [`ROB_TAG_LEN-1:0] sel_tag;
    logic [`XLEN-1:0]        sel_value;
    int                      cand;

    // Search from rr_ptr upward with wrap; first valid requester wins.
    // Reset and flush suppress every grant.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        sel_tag   = '0;
        sel_value = '0;
        cand      = 0;
        if (!reset && !flush) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                cand = int'(rr_ptr) + off;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (!grant_any && req_valid[cand]) begin
                    grant_any   = 1'b1;
                    grant[cand] = 1'b1;
                    grant_idx   = cand[REQ_IDX_W-1:0];
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    sel_tag   = req_rob_tag[i*`ROB_TAG_LEN +: `ROB_TAG_LEN];
                    sel_value = req_value[i*`XLEN +: `XLEN];
                end
            end
        end
    end

    assign req_ready = grant;

    // Register the broadcast and advance the pointer past each winner.
    // Tag 0 is the "no tag" marker: the request is consumed but not broadcast,
    // and the last broadcast payload is left untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr      <= '0;
            cdb_valid   <= 1'b0;
            cdb_rob_tag <= '0;
            cdb_value   <= '0;
            cdb_src     <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0
                                                               : grant_idx + REQ_IDX_W'(1);
            if (sel_tag != '0) begin
                cdb_valid   <= 1'b1;
                cdb_rob_tag <= sel_tag;
                cdb_value   <= sel_value;
                cdb_src     <= grant_idx;
            end else begin
                cdb_valid <= 1'b0;
            end
        end else begin
            cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_PERF_CNT_EN
    logic conflict;
    assign conflict = ($countones(req_valid) >= 2) && !flush;

    // Saturating counters: transfers per requester (tag-0 drops included)
    // and cycles with two or more valid requesters outside a flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_grant_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && perf_grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF) begin
                    perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
                end
            end
            if (conflict && perf_conflict_cnt != 32'hFFFF_FFFF) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter with NUM_REQ=3.
// Inputs change 1 time unit after a rising edge; combinational req_ready is
// checked 1 unit after that, registered cdb_* just after each rising edge.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_cdb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int IDX_W   = 2;
    localparam int TW      = `ROB_TAG_LEN;
    localparam int XW      = `XLEN;

    logic                    clock;
    logic                    reset;
    logic                    flush;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*TW-1:0]   req_rob_tag;
    logic [NUM_REQ*XW-1:0]   req_value;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    cdb_valid;
    logic [TW-1:0]           cdb_rob_tag;
    logic [XW-1:0]           cdb_value;
    logic [IDX_W-1:0]        cdb_src;
`ifdef CDB_PERF_CNT_EN
    logic [NUM_REQ*32-1:0]   perf_grant_cnt;
    logic [31:0]             perf_conflict_cnt;
`endif

    int total;
    int bad;

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .REQ_IDX_W(IDX_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_rob_tag (req_rob_tag),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .cdb_valid   (cdb_valid),
        .cdb_rob_tag (cdb_rob_tag),
        .cdb_value   (cdb_value),
        .cdb_src     (cdb_src)
`ifdef CDB_PERF_CNT_EN
        ,
        .perf_grant_cnt    (perf_grant_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    // Clock generation.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive all requesters; tags/values per slot.
    task automatic drive(input logic [2:0] v,
                         input logic [TW-1:0] t0, input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                         input logic [XW-1:0] d0, input logic [XW-1:0] d1, input logic [XW-1:0] d2);
        req_valid   = v;
        req_rob_tag = {t2, t1, t0};
        req_value   = {d2, d1, d0};
        #1;
    endtask

    // Expected per-slot payloads used in contention tests.
    logic [TW-1:0] exp_tag [3];
    logic [XW-1:0] exp_val [3];
    logic [2:0]    exp_oh  [3];

    initial begin
        total = 0;
        bad   = 0;
        exp_tag[0] = 5'd1;  exp_tag[1] = 5'd2;  exp_tag[2] = 5'd3;
        exp_val[0] = 32'h0000_1000; exp_val[1] = 32'h0000_1001; exp_val[2] = 32'h0000_1002;
        exp_oh[0] = 3'b001; exp_oh[1] = 3'b010; exp_oh[2] = 3'b100;

        // Reset with requests pending: no ready, everything cleared.
        reset = 1'b1;
        flush = 1'b0;
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1000, 32'h1001, 32'h1002);
        tick();
        tick();
        chk("reset_ready", 64'(req_ready), 64'h0);
        chk("reset_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("reset_cdb_tag", 64'(cdb_rob_tag), 64'h0);
        chk("reset_cdb_value", 64'(cdb_value), 64'h0);
        chk("reset_cdb_src", 64'(cdb_src), 64'h0);
        chk("reset_rr_ptr", 64'(dut.rr_ptr), 64'h0);
        reset = 1'b0;

        // Single request from slot 1.
        drive(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0);
        chk("single_ready", 64'(req_ready), 64'h2);
        tick();
        chk("single_cdb_valid", 64'(cdb_valid), 64'h1);
        chk("single_cdb_tag", 64'(cdb_rob_tag), 64'h5);
        chk("single_cdb_value", 64'(cdb_value), 64'hDEAD_BEEF);
        chk("single_cdb_src", 64'(cdb_src), 64'h1);
        chk("single_rr_ptr", 64'(dut.rr_ptr), 64'h2);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        chk("idle_ready", 64'(req_ready), 64'h0);
        tick();
        chk("idle_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("idle_cdb_tag_hold", 64'(cdb_rob_tag), 64'h5);
        chk("idle_rr_ptr_hold", 64'(dut.rr_ptr), 64'h2);

        // Wrap with sparse requests: rr_ptr=2, slots 0 and 1 valid.
        drive(3'b011, 5'd1, 5'd2, 5'd3, 32'h1000, 32'h1001, 32'h1002);
        chk("wrap_ready0", 64'(req_ready), 64'h1);
        tick();
        chk("wrap_cdb_src0", 64'(cdb_src), 64'h0);
        chk("wrap_cdb_tag0", 64'(cdb_rob_tag), 64'h1);
        chk("wrap_rr_ptr1", 64'(dut.rr_ptr), 64'h1);
        chk("wrap_ready1", 64'(req_ready), 64'h2);
        tick();
        chk("wrap_cdb_src1", 64'(cdb_src), 64'h1);
        chk("wrap_cdb_value1", 64'(cdb_value), 64'h1001);
        chk("wrap_rr_ptr2", 64'(dut.rr_ptr), 64'h2);

        // Slot 2 alone brings the pointer back to 0.
        drive(3'b100, 5'd1, 5'd2, 5'd3, 32'h1000, 32'h1001, 32'h1002);
        chk("solo2_ready", 64'(req_ready), 64'h4);
        tick();
        chk("solo2_cdb_src", 64'(cdb_src), 64'h2);
        chk("solo2_rr_ptr", 64'(dut.rr_ptr), 64'h0);

        // Contention fairness: order 0,1,2,0,1,2.
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1000, 32'h1001, 32'h1002);
        for (int k = 0; k < 6; k++) begin
            chk("fair_ready", 64'(req_ready), 64'(exp_oh[k % 3]));
            tick();
            chk("fair_cdb_valid", 64'(cdb_valid), 64'h1);
            chk("fair_cdb_src", 64'(cdb_src), 64'(k % 3));
            chk("fair_cdb_tag", 64'(cdb_rob_tag), 64'(exp_tag[k % 3]));
            chk("fair_cdb_value", 64'(cdb_value), 64'(exp_val[k % 3]));
        end
        chk("fair_rr_ptr", 64'(dut.rr_ptr), 64'h0);

        // Flush for two cycles during contention.
        flush = 1'b1;
        #1;
        chk("flush_prev_bcast_visible", 64'(cdb_valid), 64'h1);
        chk("flush_ready_c1", 64'(req_ready), 64'h0);
        tick();
        chk("flush_cdb_valid_c1", 64'(cdb_valid), 64'h0);
        chk("flush_rr_ptr_c1", 64'(dut.rr_ptr), 64'h0);
        chk("flush_ready_c2", 64'(req_ready), 64'h0);
        tick();
        chk("flush_cdb_valid_c2", 64'(cdb_valid), 64'h0);
        chk("flush_rr_ptr_c2", 64'(dut.rr_ptr), 64'h0);
        flush = 1'b0;
        #1;
        chk("resume_ready", 64'(req_ready), 64'h1);
        tick();
        chk("resume_cdb_valid", 64'(cdb_valid), 64'h1);
        chk("resume_cdb_src", 64'(cdb_src), 64'h0);
        chk("resume_rr_ptr", 64'(dut.rr_ptr), 64'h1);

        // Tag-0 request: acknowledged, pointer advances, nothing broadcast.
        drive(3'b001, 5'd0, 5'd2, 5'd3, 32'h1234, 32'h1001, 32'h1002);
        chk("tag0_ready", 64'(req_ready), 64'h1);
        tick();
        chk("tag0_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("tag0_rr_ptr", 64'(dut.rr_ptr), 64'h1);

        // Reset during contention.
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1000, 32'h1001, 32'h1002);
        chk("prerst_ready", 64'(req_ready), 64'h2);
        tick();
        chk("prerst_cdb_src", 64'(cdb_src), 64'h1);
        reset = 1'b1;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'h0);
        tick();
        chk("midrst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("midrst_rr_ptr", 64'(dut.rr_ptr), 64'h0);
        chk("midrst_cdb_value", 64'(cdb_value), 64'h0);
`ifdef CDB_PERF_CNT_EN
        chk("midrst_conflict_cnt", 64'(perf_conflict_cnt), 64'h0);
        chk("midrst_grant_cnt", 64'(perf_grant_cnt), 64'h0);
`endif
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("postrst_ready", 64'(req_ready), 64'(exp_oh[k % 3]));
            tick();
            chk("postrst_cdb_src", 64'(cdb_src), 64'(k % 3));
        end
`ifdef CDB_PERF_CNT_EN
        chk("perf_conflict_cnt", 64'(perf_conflict_cnt), 64'h4);
        chk("perf_grant0", 64'(perf_grant_cnt[0 +: 32]), 64'h2);
        chk("perf_grant1", 64'(perf_grant_cnt[32 +: 32]), 64'h1);
        chk("perf_grant2", 64'(perf_grant_cnt[64 +: 32]), 64'h1);
`endif
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("final_cdb_valid", 64'(cdb_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
